// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths, reset instruction and FSM encoding for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

    localparam int unsigned RegAddrW  = 16;
    localparam int unsigned RegValueW = 16;
    localparam int unsigned WaitCntW  = 4;

    localparam logic [RegValueW-1:0] NopInst = 16'h0800;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StWrec  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction SRAM controller: wait-state reads and program-load writes, with a one-entry
// fetch buffer that returns a repeated PC in one cycle without touching the SRAM.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_W      = RegAddrW,
    parameter int unsigned          DATA_W      = RegValueW,
    parameter int unsigned          SRAM_AW     = 18,
    parameter int unsigned          WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0]    NOP_INST    = NopInst
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               pc_req,
    input  logic               flush,
    output logic [DATA_W-1:0]  inst,
    output logic               inst_valid,
    output logic               stall,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [DATA_W-1:0]  load_data,
    output logic               load_ack,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [DATA_W-1:0]  sram_dq_in,
    output logic [DATA_W-1:0]  sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam logic [WaitCntW-1:0] WaitInit = WaitCntW'(WAIT_CYCLES);

    fetch_state_e          state_q, state_d;
    logic [WaitCntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]     inst_q, inst_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  load_ack_q, load_ack_d;
    logic [SRAM_AW-1:0]    sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]     dq_out_q, dq_out_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  ce_n_q, ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic [ADDR_W-1:0]     tag_q, tag_d;
    logic [DATA_W-1:0]     buf_data_q, buf_data_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  hit;

    assign hit = buf_valid_q && (tag_q == pc);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        load_ack_d   = 1'b0;
        sram_addr_d  = sram_addr_q;
        dq_out_d     = dq_out_q;
        dq_oe_d      = dq_oe_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        tag_d        = tag_q;
        buf_data_d   = buf_data_q;
        buf_valid_d  = buf_valid_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        flush_pend_d = flush_pend_q;

        unique case (state_q)
            StIdle: begin
                if (load_en) begin
                    wr_addr_d   = load_addr;
                    dq_out_d    = load_data;
                    sram_addr_d = SRAM_AW'(load_addr);
                    cnt_d       = WaitInit;
                    ce_n_d      = 1'b0;
                    we_n_d      = 1'b0;
                    oe_n_d      = 1'b1;
                    dq_oe_d     = 1'b1;
                    state_d     = StWrite;
                end else if (pc_req && hit) begin
                    if (flush) begin
                        inst_d = NOP_INST;
                    end else begin
                        inst_d       = buf_data_q;
                        inst_valid_d = 1'b1;
                    end
                end else if (pc_req) begin
                    rd_addr_d    = pc;
                    sram_addr_d  = SRAM_AW'(pc);
                    cnt_d        = WaitInit;
                    ce_n_d       = 1'b0;
                    oe_n_d       = 1'b0;
                    flush_pend_d = 1'b0;
                    state_d      = StRead;
                end
            end

            StRead: begin
                cnt_d = cnt_q - 1'b1;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    // The buffer is filled even for a flushed fetch; only the result is dropped.
                    tag_d        = rd_addr_q;
                    buf_data_d   = sram_dq_in;
                    buf_valid_d  = 1'b1;
                    cnt_d        = '0;
                    ce_n_d       = 1'b1;
                    oe_n_d       = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = StIdle;
                    if (flush || flush_pend_q) begin
                        inst_d = NOP_INST;
                    end else begin
                        inst_d       = sram_dq_in;
                        inst_valid_d = 1'b1;
                    end
                end
            end

            StWrite: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d      = '0;
                    we_n_d     = 1'b1;
                    load_ack_d = 1'b1;
                    state_d    = StWrec;
                end
            end

            StWrec: begin
                // Keep the buffered copy coherent with the word just written.
                if (buf_valid_q && (tag_q == wr_addr_q)) begin
                    buf_data_d = dq_out_q;
                end
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            load_ack_q   <= 1'b0;
            sram_addr_q  <= '0;
            dq_out_q     <= '0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            tag_q        <= '0;
            buf_data_q   <= '0;
            buf_valid_q  <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            load_ack_q   <= load_ack_d;
            sram_addr_q  <= sram_addr_d;
            dq_out_q     <= dq_out_d;
            dq_oe_q      <= dq_oe_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            tag_q        <= tag_d;
            buf_data_q   <= buf_data_d;
            buf_valid_q  <= buf_valid_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign stall       = (state_q != StIdle);
    assign load_ack    = load_ack_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl against a small behavioural SRAM.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        pc_req;
    logic        flush;
    logic [15:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic        load_ack;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    inst_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_req      (pc_req),
        .flush       (flush),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .stall       (stall),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ack    (load_ack),
        .sram_addr   (sram_addr),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    // Preload happens under reset, so a write aborted by reset leaves the preload in place.
    always @(posedge clk) begin
        if (rst) begin
            mem[8'h04] <= 16'h7940;
            mem[8'h10] <= 16'h5555;
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        pc        = '0;
        pc_req    = 1'b0;
        flush     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_inst", 32'(inst), 32'h0800);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_ce_n", 32'(sram_ce_n), 32'h1);
        check("rst_oe_n", 32'(sram_oe_n), 32'h1);
        check("rst_we_n", 32'(sram_we_n), 32'h1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        check("rst_ack", 32'(load_ack), 32'h0);
        tick();
        check("idle_stall", 32'(stall), 32'h0);

        // Miss on 0x0004
        pc = 16'h0004; pc_req = 1'b1;
        tick();
        pc_req = 1'b0;
        check("miss_c1_stall", 32'(stall), 32'h1);
        check("miss_c1_ce_n", 32'(sram_ce_n), 32'h0);
        check("miss_c1_oe_n", 32'(sram_oe_n), 32'h0);
        check("miss_c1_addr", 32'(sram_addr), 32'h00004);
        check("miss_c1_valid", 32'(inst_valid), 32'h0);
        tick();
        check("miss_c2_stall", 32'(stall), 32'h1);
        check("miss_c2_valid", 32'(inst_valid), 32'h0);
        tick();
        check("miss_c3_stall", 32'(stall), 32'h0);
        check("miss_c3_valid", 32'(inst_valid), 32'h1);
        check("miss_c3_inst", 32'(inst), 32'h7940);
        check("miss_c3_ce_n", 32'(sram_ce_n), 32'h1);

        // Hit on the same PC
        pc_req = 1'b1;
        tick();
        pc_req = 1'b0;
        check("hit_valid", 32'(inst_valid), 32'h1);
        check("hit_inst", 32'(inst), 32'h7940);
        check("hit_stall", 32'(stall), 32'h0);
        check("hit_ce_n", 32'(sram_ce_n), 32'h1);
        tick();
        check("hit_pulse_end", 32'(inst_valid), 32'h0);

        // Program load to the buffered address
        load_en = 1'b1; load_addr = 16'h0004; load_data = 16'hABCD;
        tick();
        check("wr_c1_we_n", 32'(sram_we_n), 32'h0);
        check("wr_c1_stall", 32'(stall), 32'h1);
        check("wr_c1_dq_oe", 32'(sram_dq_oe), 32'h1);
        check("wr_c1_dq_out", 32'(sram_dq_out), 32'hABCD);
        check("wr_c1_ack", 32'(load_ack), 32'h0);
        tick();
        check("wr_c2_we_n", 32'(sram_we_n), 32'h0);
        check("wr_c2_ack", 32'(load_ack), 32'h0);
        tick();
        load_en = 1'b0;
        check("wrec_we_n", 32'(sram_we_n), 32'h1);
        check("wrec_ack", 32'(load_ack), 32'h1);
        check("wrec_ce_n", 32'(sram_ce_n), 32'h0);
        check("wrec_dq_oe", 32'(sram_dq_oe), 32'h1);
        tick();
        check("wr_done_ack", 32'(load_ack), 32'h0);
        check("wr_done_stall", 32'(stall), 32'h0);
        check("wr_done_dq_oe", 32'(sram_dq_oe), 32'h0);
        pc = 16'h0004; pc_req = 1'b1;
        tick();
        pc_req = 1'b0;
        check("coh_hit_valid", 32'(inst_valid), 32'h1);
        check("coh_hit_inst", 32'(inst), 32'hABCD);
        check("coh_hit_stall", 32'(stall), 32'h0);

        // load_en and pc_req together: write first, fetch after ack
        load_en = 1'b1; load_addr = 16'h0008; load_data = 16'h1234;
        pc = 16'h0008; pc_req = 1'b1;
        tick();
        check("both_write_first", 32'(sram_we_n), 32'h0);
        check("both_oe_n", 32'(sram_oe_n), 32'h1);
        tick();
        tick();
        check("both_ack", 32'(load_ack), 32'h1);
        load_en = 1'b0;
        tick();
        check("both_idle_stall", 32'(stall), 32'h0);
        check("both_idle_valid", 32'(inst_valid), 32'h0);
        tick();
        pc_req = 1'b0;
        check("both_read_stall", 32'(stall), 32'h1);
        check("both_read_addr", 32'(sram_addr), 32'h00008);
        check("both_read_oe_n", 32'(sram_oe_n), 32'h0);
        tick();
        tick();
        check("both_read_valid", 32'(inst_valid), 32'h1);
        check("both_read_inst", 32'(inst), 32'h1234);

        // Flush during READ
        pc = 16'h0010; pc_req = 1'b1;
        tick();
        pc_req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("flush_rd_valid", 32'(inst_valid), 32'h0);
        check("flush_rd_inst", 32'(inst), 32'h0800);
        check("flush_rd_stall", 32'(stall), 32'h0);
        pc_req = 1'b1;
        tick();
        pc_req = 1'b0;
        check("flush_fill_valid", 32'(inst_valid), 32'h1);
        check("flush_fill_inst", 32'(inst), 32'h5555);

        // Flush on a hit in IDLE
        pc_req = 1'b1; flush = 1'b1;
        tick();
        pc_req = 1'b0; flush = 1'b0;
        check("flush_hit_valid", 32'(inst_valid), 32'h0);
        check("flush_hit_inst", 32'(inst), 32'h0800);

        // Reset in the second WRITE cycle
        load_en = 1'b1; load_addr = 16'h0010; load_data = 16'h9999;
        tick();
        tick();
        check("rstw_we_n_low", 32'(sram_we_n), 32'h0);
        rst = 1'b1; load_en = 1'b0;
        tick();
        rst = 1'b0;
        check("rstw_we_n", 32'(sram_we_n), 32'h1);
        check("rstw_ack", 32'(load_ack), 32'h0);
        check("rstw_stall", 32'(stall), 32'h0);
        check("rstw_dq_oe", 32'(sram_dq_oe), 32'h0);
        tick();
        check("rstw_ack_later", 32'(load_ack), 32'h0);
        pc = 16'h0010; pc_req = 1'b1;
        tick();
        pc_req = 1'b0;
        check("rstw_miss_stall", 32'(stall), 32'h1);
        check("rstw_miss_ce_n", 32'(sram_ce_n), 32'h0);
        tick();
        tick();
        check("rstw_miss_valid", 32'(inst_valid), 32'h1);
        check("rstw_miss_inst", 32'(inst), 32'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Parametrised instruction-memory controller: serves CPU fetch requests from external asynchronous SRAM through a wait-state FSM. It also accepts program-load writes from the bootloader/serial path. A one-entry fetch buffer returns repeated addresses in 1 cycle; misses stall the pipeline. Sits between the IF stage and the instruction SRAM bank.

Parameters:
ADDR_W, 16, CPU PC width (matches RegAddr)
DATA_W, 16, instruction width (matches RegValue)
SRAM_AW, 18, external SRAM address width; PC zero-extended into it
WAIT_CYCLES, 1, extra SRAM access cycles beyond the first (0..15)
NOP_INST, 16'h0800, instruction emitted on reset/flush

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
pc  in  ADDR_W  fetch address, sampled when pc_req=1 in IDLE
pc_req  in  1  fetch request
flush  in  1  cancel in-flight fetch result (branch taken)
inst  out  DATA_W  fetched instruction, registered
inst_valid  out  1  one-cycle pulse: inst is new
stall  out  1  high while state != IDLE
load_en  in  1  program-load write request, held until load_ack
load_addr  in  ADDR_W  write address
load_data  in  DATA_W  write data
load_ack  out  1  one-cycle pulse at write completion
sram_addr  out  SRAM_AW  SRAM address, registered
sram_dq_in  in  DATA_W  SRAM read data
sram_dq_out  out  DATA_W  SRAM write data
sram_dq_oe  out  1  drive dq bus (top level builds tristate)
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low

Behaviour:
- Reset (synchronous, any state): state=IDLE; inst=NOP_INST; inst_valid=0; load_ack=0; sram_addr=0; sram_dq_out=0; dq_oe=0; ce_n=oe_n=we_n=1; buffer valid bit=0; wait counter=0. Reset mid-read or mid-write aborts immediately, with no ack and no valid.
- States: IDLE, READ, WRITE, WREC (write recovery).
- IDLE: load_en has priority over pc_req. load_en=1: latch load_addr/load_data, go to WRITE. Else pc_req=1 with buffer valid and tag==pc (hit): next cycle inst=buffer data, inst_valid=1, stay IDLE. A hit has 1-cycle latency and no stall. Else pc_req=1 (miss): latch pc into sram_addr, counter=WAIT_CYCLES, go to READ.
- READ: ce_n=0, oe_n=0. Decrement counter each cycle. The cycle counter==0 samples sram_dq_in into inst and buffer (tag=latched pc, valid=1), pulses inst_valid, and returns to IDLE. Miss latency is WAIT_CYCLES+2 cycles from the pc_req sample to inst_valid (3 cycles at the default).
- flush while in READ: the read still completes, the buffer is still filled, but inst=NOP_INST and inst_valid is suppressed. flush in IDLE with a hit in the same cycle: inst=NOP_INST, no valid. flush is otherwise ignored.
- pc_req dropping mid-READ has no effect; the fetch completes normally.
- WRITE: ce_n=0, we_n=0, dq_oe=1, sram_dq_out=latched data, for WAIT_CYCLES+1 cycles, then go to WREC.
- WREC: 1 cycle. we_n=1 while ce_n=0 and dq_oe=1 are held (data hold). load_ack=1. If buffer tag==load_addr, the buffer data is updated to load_data (coherent). Then go to IDLE.
- load_en is ignored outside IDLE. The requester holds it until load_ack. load_en still high in the IDLE cycle after load_ack starts a new write, so the bootloader must drop it on ack.
- stall = (state != IDLE), combinational from the state register.
- inst holds its last value between valid pulses. Outputs other than stall are registered.
- SRAM address = {zeros, pc} (zero-extended). Counter width is 4 bits.

Decomposition:
- Shared package/define file: NOP_INST value, state encodings, RegAddr/RegValue widths.
- Single module. The wait counter and the buffer are inline; no sub-module is warranted.

Test Plan:
- Reset, then idle: inst=16'h0800, inst_valid=0, stall=0, ce_n/oe_n/we_n=1, dq_oe=0.
- Miss, WAIT_CYCLES=1: pc=16'h0004, model returns 16'h7940 -> stall high 2 cycles, inst=16'h7940 with inst_valid on cycle 3, sram_addr=18'h00004.
- Hit: repeat pc=16'h0004 after a miss -> inst_valid next cycle, no stall, sram_ce_n stays 1.
- Load then fetch: load 16'hABCD to 16'h0004 while it is buffered -> we_n low 2 cycles, load_ack on cycle 3, next fetch of 16'h0004 hits and returns 16'hABCD.
- Simultaneous load_en and pc_req in IDLE -> write is performed first; the fetch starts only after load_ack (with pc_req still held).
- flush during READ -> no inst_valid, inst=16'h0800. Reset asserted in the second WRITE cycle -> no load_ack, we_n=1 next cycle, buffer invalid (next fetch misses).
